// File: rtl/obf_key_loader.sv
// -----------------------------------------------------------------------------
// obf_key_loader
//   Serial loader for the select key of a logic-obfuscation fabric. A key is
//   shifted in MSB-first, followed by one even-parity bit. A good key is
//   committed to d_key atomically; a bad one raises key_error and leaves d_key
//   untouched. Once a key commits the loader locks until reset.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous active-high reset
//   key_start  : single-cycle request to begin a key load
//   key_bit    : serial key / parity bit
//   key_valid  : key_bit is valid this cycle
//   key_ready  : loader accepts a bit this cycle (decoded from state)
//   d_key      : select bus, site i uses [2i+1:2i]
//                (00 net, 01 inverted net, 10 const1, 11 const0)
//   key_done   : one-cycle pulse when a key commits
//   key_error  : level, set after a parity failure
//   key_locked : level, set once a key has committed
// -----------------------------------------------------------------------------
module obf_key_loader #(
  parameter int NUM_SITES = 5,
  parameter int KEY_W     = 2 * NUM_SITES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_start,
  input  logic             key_bit,
  input  logic             key_valid,
  output logic             key_ready,
  output logic [KEY_W-1:0] d_key,
  output logic             key_done,
  output logic             key_error,
  output logic             key_locked
);

  localparam int CNT_W = $clog2(KEY_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Elaboration-time guard: every site needs exactly two select bits.
  if (KEY_W != 2 * NUM_SITES) begin : g_bad_key_w
    $error("obf_key_loader: KEY_W must equal 2*NUM_SITES");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    PARITY = 3'd2,
    COMMIT = 3'd3,
    LOCKED = 3'd4,
    ERR    = 3'd5
  } state_t;

  // Even parity: the parity bit must make the total count of ones even.
  function automatic logic even_parity(input logic [KEY_W-1:0] v);
    return ^v;
  endfunction

  state_t             state_r;
  state_t             state_s;
  logic [KEY_W-1:0]   shift_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               commit_r;
  logic               ready_s;
  logic               transfer_s;
  logic               start_take_s;
  logic               parity_ok_s;

  // Next-state decode plus the handshake signals derived from the state.
  always_comb begin
    state_s      = state_r;
    ready_s      = 1'b0;
    start_take_s = 1'b0;
    case (state_r)
      IDLE: begin
        start_take_s = key_start;
        if (key_start) begin
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        ready_s = 1'b1;
        if (key_valid && (cnt_r == CNT_LAST)) begin
          state_s = PARITY;
        end else begin
          state_s = SHIFT;
        end
      end
      PARITY: begin
        ready_s = 1'b1;
        if (key_valid) begin
          if (parity_ok_s) begin
            state_s = COMMIT;
          end else begin
            state_s = ERR;
          end
        end else begin
          state_s = PARITY;
        end
      end
      COMMIT: begin
        state_s = LOCKED;
      end
      LOCKED: begin
        state_s = LOCKED;
      end
      ERR: begin
        start_take_s = key_start;
        if (key_start) begin
          state_s = SHIFT;
        end else begin
          state_s = ERR;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign transfer_s  = key_valid && ready_s;
  assign parity_ok_s = (even_parity(shift_r) == key_bit);
  assign key_ready   = ready_s;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Shift register, transfer counter and registered outputs. The commit is
  // staged through commit_r so d_key and key_done change together two edges
  // after the parity transfer, with the whole key swapped in at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r    <= '0;
      cnt_r      <= '0;
      commit_r   <= 1'b0;
      d_key      <= '0;
      key_done   <= 1'b0;
      key_error  <= 1'b0;
      key_locked <= 1'b0;
    end else begin
      commit_r <= (state_r == COMMIT);
      key_done <= commit_r;

      if (start_take_s) begin
        shift_r   <= '0;
        cnt_r     <= '0;
        key_error <= 1'b0;
      end else if ((state_r == SHIFT) && transfer_s) begin
        shift_r <= {shift_r[KEY_W-2:0], key_bit};
        cnt_r   <= (cnt_r == CNT_LAST) ? '0 : (cnt_r + CNT_ONE);
      end else if ((state_r == PARITY) && transfer_s && !parity_ok_s) begin
        key_error <= 1'b1;
      end else begin
        shift_r <= shift_r;
      end

      if (commit_r) begin
        d_key      <= shift_r;
        key_locked <= 1'b1;
      end else begin
        d_key <= d_key;
      end
    end
  end

endmodule

// File: tb/tb_obf_key_loader.sv
// -----------------------------------------------------------------------------
// tb_obf_key_loader
//   Table-driven bench for obf_key_loader (NUM_SITES=5, KEY_W=10) plus short
//   hand-written sequences for restart, stall, error and reset corner cases.
// -----------------------------------------------------------------------------
module tb_obf_key_loader;

  localparam int NS = 5;
  localparam int KW = 2 * NS;

  logic          clk;
  logic          rst;
  logic          key_start;
  logic          key_bit;
  logic          key_valid;
  logic          key_ready;
  logic [KW-1:0] d_key;
  logic          key_done;
  logic          key_error;
  logic          key_locked;

  int checks;
  int failures;

  obf_key_loader #(.NUM_SITES(NS), .KEY_W(KW)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_start  (key_start),
    .key_bit    (key_bit),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .d_key      (d_key),
    .key_done   (key_done),
    .key_error  (key_error),
    .key_locked (key_locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [KW-1:0] key;
    logic          par;
    int            gap_max;
    logic [KW-1:0] exp_key;
    logic          exp_err;
    logic          exp_lock;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs and samples both sit 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_ready"},  {31'd0, key_ready},  32'd0);
    chk({tag, "_dkey"},   {22'd0, d_key},      32'd0);
    chk({tag, "_done"},   {31'd0, key_done},   32'd0);
    chk({tag, "_error"},  {31'd0, key_error},  32'd0);
    chk({tag, "_locked"}, {31'd0, key_locked}, 32'd0);
  endtask

  task automatic pulse_start();
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
  endtask

  // Optional stall, then one transfer; the loader must be ready for it.
  task automatic send_bit(input logic b, input int gap, input string tag);
    key_valid = 1'b0;
    for (int g = 0; g < gap; g++) tick();
    chk({tag, "_ready_before_bit"}, {31'd0, key_ready}, 32'd1);
    key_bit   = b;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic send_key_bits(input logic [KW-1:0] k, input int hi, input int lo,
                               input int gap_max, input string tag);
    for (int i = hi; i >= lo; i--) begin
      send_bit(k[i], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0, tag);
    end
  endtask

  // Called 1ns after the parity-transfer edge; follows the commit timeline.
  task automatic check_commit(input logic [KW-1:0] prev_key, input logic [KW-1:0] exp_key,
                              input logic exp_err, input logic exp_lock, input string tag);
    chk({tag, "_ready_after_par"}, {31'd0, key_ready}, 32'd0);
    chk({tag, "_err_e0"},          {31'd0, key_error}, {31'd0, exp_err});
    tick();
    chk({tag, "_dkey_e1"},  {22'd0, d_key},    {22'd0, prev_key});
    chk({tag, "_done_e1"},  {31'd0, key_done}, 32'd0);
    tick();
    chk({tag, "_dkey_e2"},   {22'd0, d_key},      {22'd0, exp_key});
    chk({tag, "_done_e2"},   {31'd0, key_done},   {31'd0, exp_lock});
    chk({tag, "_locked_e2"}, {31'd0, key_locked}, {31'd0, exp_lock});
    chk({tag, "_error_e2"},  {31'd0, key_error},  {31'd0, exp_err});
    tick();
    chk({tag, "_done_e3"}, {31'd0, key_done}, 32'd0);
    chk({tag, "_dkey_e3"}, {22'd0, d_key},    {22'd0, exp_key});
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    key_start = 1'b0;
    key_bit   = 1'b0;
    key_valid = 1'b0;

    // key, parity, max gap, expected d_key, error, locked
    vecs[0] = '{10'h272, 1'b1, 0, 10'h272, 1'b0, 1'b1};
    vecs[1] = '{10'h272, 1'b1, 7, 10'h272, 1'b0, 1'b1};
    vecs[2] = '{10'h3FF, 1'b0, 0, 10'h3FF, 1'b0, 1'b1};
    vecs[3] = '{10'h272, 1'b0, 0, 10'h000, 1'b1, 1'b0};
    vecs[4] = '{10'h155, 1'b1, 3, 10'h155, 1'b0, 1'b1};
    vecs[5] = '{10'h001, 1'b1, 0, 10'h001, 1'b0, 1'b1};

    tick();
    for (int v = 0; v < 6; v++) begin
      do_reset();
      check_reset_state($sformatf("v%0d_rst", v));
      pulse_start();
      send_key_bits(vecs[v].key, KW - 1, 0, vecs[v].gap_max, $sformatf("v%0d", v));
      chk($sformatf("v%0d_par_ready", v), {31'd0, key_ready}, 32'd1);
      send_bit(vecs[v].par, 0, $sformatf("v%0d_par", v));
      check_commit(10'h000, vecs[v].exp_key, vecs[v].exp_err, vecs[v].exp_lock,
                   $sformatf("v%0d", v));
    end

    // All-ones key: every site selects const0 (11).
    do_reset();
    pulse_start();
    send_key_bits(10'h3FF, KW - 1, 0, 0, "ones");
    send_bit(1'b0, 0, "ones_par");
    tick();
    tick();
    for (int s = 0; s < NS; s++) begin
      chk($sformatf("ones_site%0d", s), {30'd0, d_key[2*s +: 2]}, 32'd3);
    end

    // Parity error, then a correct reload commits and clears key_error.
    do_reset();
    pulse_start();
    send_key_bits(10'h272, KW - 1, 0, 0, "err");
    send_bit(1'b0, 0, "err_par");
    check_commit(10'h000, 10'h000, 1'b1, 1'b0, "err");
    pulse_start();
    chk("err_restart_error_clr", {31'd0, key_error}, 32'd0);
    chk("err_restart_ready",     {31'd0, key_ready}, 32'd1);
    send_key_bits(10'h272, KW - 1, 0, 0, "reload");
    send_bit(1'b1, 0, "reload_par");
    check_commit(10'h000, 10'h272, 1'b0, 1'b1, "reload");

    // key_start during SHIFT is ignored; key_start/key_valid while LOCKED too.
    do_reset();
    pulse_start();
    send_key_bits(10'h272, KW - 1, KW - 4, 0, "mid");
    pulse_start();
    chk("mid_start_ready", {31'd0, key_ready}, 32'd1);
    send_key_bits(10'h272, KW - 5, 0, 0, "mid");
    send_bit(1'b1, 0, "mid_par");
    check_commit(10'h000, 10'h272, 1'b0, 1'b1, "mid");
    pulse_start();
    key_valid = 1'b1;
    key_bit   = 1'b1;
    tick();
    tick();
    key_valid = 1'b0;
    chk("lock_start_dkey",   {22'd0, d_key},      32'h272);
    chk("lock_start_ready",  {31'd0, key_ready},  32'd0);
    chk("lock_start_locked", {31'd0, key_locked}, 32'd1);
    chk("lock_start_done",   {31'd0, key_done},   32'd0);

    // key_start with key_valid in IDLE: start taken, bit not consumed.
    do_reset();
    key_start = 1'b1;
    key_valid = 1'b1;
    key_bit   = 1'b1;
    tick();
    key_start = 1'b0;
    key_valid = 1'b0;
    send_key_bits(10'h272, KW - 1, 0, 0, "sv");
    send_bit(1'b1, 0, "sv_par");
    check_commit(10'h000, 10'h272, 1'b0, 1'b1, "sv");

    // Reset after six bits discards the partial key; a fresh load commits.
    do_reset();
    pulse_start();
    send_key_bits(10'h3FF, KW - 1, KW - 6, 0, "rmid");
    key_valid = 1'b1;
    key_bit   = 1'b1;
    key_start = 1'b1;
    do_reset();
    key_valid = 1'b0;
    key_start = 1'b0;
    check_reset_state("rmid");
    pulse_start();
    send_key_bits(10'h272, KW - 1, 0, 0, "rnew");
    send_bit(1'b1, 0, "rnew_par");
    check_commit(10'h000, 10'h272, 1'b0, 1'b1, "rnew");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/obf_key_loader.md
OBF_KEY_LOADER -- requirements
Module: obf_key_loader

Interface
REQ-001 SHALL have parameter NUM_SITES, default 5, giving the number of obfuscated nets, each configured by a 2-bit select.
REQ-002 SHALL have parameter KEY_W, default 2*NUM_SITES, giving the key width; KEY_W other than 2*NUM_SITES is illegal.
REQ-003 SHALL have one clock and a synchronous, active-high reset, named as below.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port key_start, input, 1 bit: single-cycle request to begin a key load.
REQ-007 SHALL have port key_bit, input, 1 bit: serial key or parity bit.
REQ-008 SHALL have port key_valid, input, 1 bit: key_bit is valid this cycle.
REQ-009 SHALL have port key_ready, output, 1 bit: the loader accepts a bit this cycle.
REQ-010 SHALL have port d_key, output, KEY_W bits: select bus to the obfuscated cells; site i uses bits [2i+1:2i]; 00 = net, 01 = inverted net, 10 = const1, 11 = const0.
REQ-011 SHALL have port key_done, output, 1 bit: one-cycle pulse when a load commits.
REQ-012 SHALL have port key_error, output, 1 bit: level; high after a parity failure.
REQ-013 SHALL have port key_locked, output, 1 bit: level; high once a key has committed.

Function
REQ-014 SHALL implement an FSM with states IDLE, SHIFT, PARITY, COMMIT, LOCKED and ERR.
REQ-015 IDLE: key_ready=0; key_start moves the FSM to SHIFT, clears the shift register and bit counter, and clears key_error.
REQ-016 SHIFT: key_ready=1; a bit transfers only when key_valid and key_ready are both 1 in the same cycle, and is shifted in MSB-first.
REQ-017 The bit counter SHALL count transfers modulo KEY_W; on the KEY_W-th transfer the FSM moves to PARITY.
REQ-018 Cycles with key_valid=0 SHALL not advance the counter, so stalls of any length are legal.
REQ-019 PARITY: key_ready=1; the next transfer is an even-parity bit over the KEY_W shifted bits.
REQ-020 A parity match SHALL move the FSM to COMMIT; a mismatch SHALL move it to ERR.
REQ-021 COMMIT: d_key is loaded from the shift register in a single cycle (no partial key ever appears on d_key), key_done pulses for exactly 1 cycle, key_locked is set, and the next state is LOCKED.
REQ-022 Latency SHALL be exactly 2 cycles from the parity-bit transfer edge to d_key updating and key_done rising.
REQ-023 LOCKED: key_ready=0, key_start is ignored, and d_key holds; only rst leaves LOCKED.
REQ-024 ERR: key_error=1, key_ready=0, and d_key keeps its previous value; key_start returns the FSM to SHIFT (via the IDLE actions of REQ-015).
REQ-025 key_start SHALL be ignored in SHIFT and PARITY; an in-progress load is not restarted.
REQ-026 key_valid outside SHIFT and PARITY SHALL be ignored, and no bit is consumed.
REQ-027 key_start and key_valid high in the same IDLE cycle: the start is taken, and the bit is not consumed because key_ready=0.
REQ-028 All outputs SHALL be registered, except key_ready, which is decoded from the state.

Reset
REQ-029 On rst=1 at a clock edge: state=IDLE, d_key=0 (all sites pass-through), key_ready=0, key_done=0, key_error=0, key_locked=0, and the counter and shift register are 0.
REQ-030 rst mid-load (SHIFT or PARITY) SHALL discard the partial key, with d_key=0 on the next cycle.
REQ-031 rst SHALL take priority over every other input in the same cycle.

Verification
REQ-032 Scenario: start, then bits 1001110010 back-to-back, then parity 1 -> d_key=10'h272 two cycles after the parity edge, key_done 1-cycle pulse, key_locked=1.
REQ-033 Scenario: same key with parity 0 -> key_error=1, d_key stays 0, key_locked=0; then a correct reload commits.
REQ-034 Scenario: random key_valid gaps of 0-7 cycles between bits -> same d_key as the back-to-back case; counter advances only on transfers.
REQ-035 Scenario: key_start while LOCKED and while in SHIFT -> ignored; d_key and the counter are unchanged.
REQ-036 Scenario: rst asserted after 6 bits -> all outputs at reset values next cycle; a new full load then commits correctly.
REQ-037 Scenario: all-ones key 10'h3FF with parity 0 -> commits; every site reads select 11 (const0).
